// File: rtl/core_if_pkg.sv
// -----------------------------------------------------------------------------
// core_if_pkg
// Shared types and constants for the decoupled instruction-fetch prefetcher.
//   fetch_entry_t : {pc, instr} pair stored in the prefetch FIFO
//   PTR_W         : FIFO pointer width for the default depth
//   INSTR_NOP     : canonical NOP (addi x0,x0,0) for downstream bubble insertion
// Optional feature macro used by the prefetcher: CORE_IF_BYPASS_EN
// -----------------------------------------------------------------------------
package core_if_pkg;

    localparam int CORE_IF_XLEN  = 32;
    localparam int CORE_IF_ILEN  = 32;
    localparam int CORE_IF_DEPTH = 4;
    localparam int PTR_W         = $clog2(CORE_IF_DEPTH);

    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [CORE_IF_XLEN-1:0] pc;
        logic [CORE_IF_ILEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/core_if_fifo.sv
// -----------------------------------------------------------------------------
// core_if_fifo
// DEPTH-entry synchronous FIFO of fetch entries with push/pop/flush.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   push, wdata     : write request and entry
//   pop             : remove head (ignored while empty or flushing)
//   flush           : clear all entries; wins over push and pop
//   rdata           : head entry (registered storage)
//   empty, count    : occupancy status
// Also contains core_if_fifo_chk, the overflow checker bound inside the FIFO.
// -----------------------------------------------------------------------------
module core_if_fifo
    import core_if_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  entry_t                 wdata,
    output entry_t                 rdata,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);

    entry_t          mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW:0]     cnt;
    logic            full;
    logic            do_push;
    logic            do_pop;

    assign empty   = (cnt == {(PW+1){1'b0}});
    assign full    = (cnt == (PW+1)'(DEPTH));
    assign do_push = push && !flush;
    assign do_pop  = pop && !flush && !empty;
    assign count   = cnt;
    assign rdata   = mem[rd_ptr];

    // Entry storage; contents need no reset because count gates validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= {PW{1'b0}};
            rd_ptr <= {PW{1'b0}};
            cnt    <= {(PW+1){1'b0}};
        end else if (flush) begin
            wr_ptr <= {PW{1'b0}};
            rd_ptr <= {PW{1'b0}};
            cnt    <= {(PW+1){1'b0}};
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (PW+1)'(1);
                2'b01:   cnt <= cnt - (PW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    core_if_fifo_chk u_chk (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .flush (flush),
        .full  (full)
    );

endmodule

// Overflow checker: the fetch credit scheme must never push into a full FIFO.
module core_if_fifo_chk (
    input logic clk,
    input logic rst,
    input logic push,
    input logic flush,
    input logic full
);

    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && !flush && full));

endmodule

// File: rtl/core_if_prefetch.sv
// -----------------------------------------------------------------------------
// core_if_prefetch
// Decoupled instruction prefetcher. Issues sequential word fetches over a
// req/gnt/rvalid interface, buffers {pc, instr} in a DEPTH-entry FIFO and hands
// them to decode over valid/ready. A redirect flushes the FIFO, squashes every
// response still owed by memory and restarts fetch at the word-aligned target.
// Ports:
//   clk_i, rst_i                      : clock, asynchronous active-high reset
//   redirect_i, redirect_pc_i         : taken branch/jump and its target
//   imem_req_o, imem_addr_o           : fetch request and word address
//   imem_gnt_i                        : request accepted
//   imem_rvalid_i, imem_rdata_i       : in-order response
//   instr_valid_o, instr_o, instr_pc_o: FIFO head towards decode (0 when idle)
//   instr_ready_i                     : decode accepts head
// Optional feature macro: CORE_IF_BYPASS_EN -- when defined, a response that
// arrives while the FIFO is empty is presented to decode in the same cycle.
// -----------------------------------------------------------------------------
module core_if_prefetch
    import core_if_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              ILEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h1000_0000,
    parameter int              DEPTH    = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [ILEN-1:0] imem_rdata_i,
    output logic            instr_valid_o,
    input  logic            instr_ready_i,
    output logic [ILEN-1:0] instr_o,
    output logic [XLEN-1:0] instr_pc_o
);

    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } entry_t;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] pc_resp;
    logic [XLEN-1:0] target;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   drop_cnt;
    logic [CW-1:0]   fifo_count;
    logic [CW-1:0]   owed;
    logic [CW:0]     credit_used;
    logic            grant;
    logic            rsp;
    logic            rsp_drop;
    logic            rsp_take;
    logic            push;
    logic            pop;
    logic            fifo_empty;
    entry_t          wr_entry;
    entry_t          head;

    assign target      = {redirect_pc_i[XLEN-1:2], 2'b00};
    // FIFO slots plus in-flight requests may never exceed DEPTH, so every
    // response is guaranteed a slot.
    assign credit_used = {1'b0, fifo_count} + {1'b0, outstanding};
    assign imem_req_o  = !rst_i && !redirect_i && (credit_used < (CW+1)'(DEPTH));
    assign imem_addr_o = fetch_pc;
    assign grant       = imem_req_o && imem_gnt_i;

    // A response with nothing outstanding (e.g. left over from before reset) is ignored.
    assign rsp      = !rst_i && imem_rvalid_i && (outstanding != {CW{1'b0}});
    assign rsp_drop = rsp && (drop_cnt != {CW{1'b0}});
    assign rsp_take = rsp && (drop_cnt == {CW{1'b0}}) && !redirect_i;
    // Responses still owed by memory at the end of this cycle.
    assign owed     = outstanding + CW'(grant) - CW'(rsp);

    assign wr_entry = '{pc: pc_resp, instr: imem_rdata_i};
    assign pop      = !fifo_empty && instr_ready_i && !redirect_i;

`ifdef CORE_IF_BYPASS_EN
    logic byp;
    assign byp           = rsp_take && fifo_empty;
    assign push          = rsp_take && !(byp && instr_ready_i);
    assign instr_valid_o = !fifo_empty || byp;
    assign instr_o       = !fifo_empty ? head.instr : (byp ? imem_rdata_i : {ILEN{1'b0}});
    assign instr_pc_o    = !fifo_empty ? head.pc    : (byp ? pc_resp      : {XLEN{1'b0}});
`else
    assign push          = rsp_take;
    assign instr_valid_o = !fifo_empty;
    assign instr_o       = !fifo_empty ? head.instr : {ILEN{1'b0}};
    assign instr_pc_o    = !fifo_empty ? head.pc    : {XLEN{1'b0}};
`endif

    core_if_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (push),
        .pop   (pop),
        .flush (redirect_i),
        .wdata (wr_entry),
        .rdata (head),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Fetch PC advances per grant, response PC per accepted response; both reload on redirect.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fetch_pc <= RESET_PC;
            pc_resp  <= RESET_PC;
        end else if (redirect_i) begin
            fetch_pc <= target;
            pc_resp  <= target;
        end else begin
            if (grant)    fetch_pc <= fetch_pc + XLEN'(4);
            if (rsp_take) pc_resp  <= pc_resp + XLEN'(4);
        end
    end

    // In-flight tracking; on redirect everything still owed belongs to the stale stream.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            outstanding <= {CW{1'b0}};
            drop_cnt    <= {CW{1'b0}};
        end else begin
            outstanding <= owed;
            if (redirect_i) begin
                drop_cnt <= owed;
            end else if (rsp_drop) begin
                drop_cnt <= drop_cnt - CW'(1);
            end else begin
                drop_cnt <= drop_cnt;
            end
        end
    end

endmodule

// File: tb/tb_core_if_prefetch.sv
module tb_core_if_prefetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    always #5 clk = ~clk;

    core_if_prefetch dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .imem_req_o    (imem_req),
        .imem_addr_o   (imem_addr),
        .imem_gnt_i    (imem_gnt),
        .imem_rvalid_i (imem_rvalid),
        .imem_rdata_i  (imem_rdata),
        .instr_valid_o (instr_valid),
        .instr_ready_i (instr_ready),
        .instr_o       (instr),
        .instr_pc_o    (instr_pc)
    );

    int total = 0;
    int bad = 0;
    int grant_cnt = 0;
    int cyc = 0;
    int lat = 1;

    logic [31:0] addr_q[$];   // expected fetch addresses, in grant order
    logic [31:0] exp_q[$];    // expected decoded PCs; instruction is ~pc

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;
    pend_t pend_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_fetch(input logic [31:0] a, input bit decoded);
        addr_q.push_back(a);
        if (decoded) exp_q.push_back(a);
    endtask

    // Hold gnt high until exactly n more grants have happened (bounded).
    task automatic grant_n(input int n);
        int target;
        bit done;
        target = grant_cnt + n;
        done = 1'b0;
        imem_gnt = 1'b1;
        for (int i = 0; i < 300 && !done; i++) begin
            @(posedge clk);
            #1;
            if (grant_cnt >= target) done = 1'b1;
        end
        imem_gnt = 1'b0;
        if (!done) begin
            total++;
            bad++;
            $display("FAIL grant_timeout actual=%0d required=%0d", grant_cnt, target);
        end
    endtask

    // Memory model: sample handshakes mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (imem_req && imem_gnt) pend_q.push_back('{addr: imem_addr, due: cyc + lat});
            if (imem_rvalid && pend_q.size() > 0) void'(pend_q.pop_front());
        end
    end

    // Memory model: present the in-order response once its latency has elapsed.
    initial begin
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                imem_rvalid = 1'b1;
                imem_rdata  = ~pend_q[0].addr;
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = 32'h0;
            end
        end
    end

    // Monitor: fetch addresses and decode handshakes against the scoreboards.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (imem_req && imem_gnt) begin
                grant_cnt++;
                if (addr_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL fetch_extra actual=%h required=none", imem_addr);
                end else begin
                    e = addr_q.pop_front();
                    chk("fetch_addr", imem_addr, e);
                end
            end
            if (instr_valid && instr_ready && !redirect) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL dec_extra actual=%h required=none", instr_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("dec_pc", instr_pc, e);
                    chk("dec_instr", instr, ~e);
                end
            end
            if (!instr_valid) begin
                chk("idle_instr", instr, 32'h0);
                chk("idle_pc", instr_pc, 32'h0);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g0;
        rst = 1'b1;
        redirect = 1'b0;
        redirect_pc = 32'h0;
        imem_gnt = 1'b0;
        instr_ready = 1'b1;

        // Reset state
        step(2);
        @(negedge clk);
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        chk("rst_valid", {31'h0, instr_valid}, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc", instr_pc, 32'h0);
        step(1);
        rst = 1'b0;
        chk("reset_addr", imem_addr, 32'h1000_0000);

        // Streaming: gnt high, 1-cycle memory, decode always ready
        lat = 1;
        for (int i = 0; i < 6; i++) expect_fetch(32'h1000_0000 + 32'(4 * i), 1'b1);
        grant_n(6);
        step(6);

        // Credit limit with decode stalled: exactly DEPTH grants
        instr_ready = 1'b0;
        for (int i = 0; i < 4; i++) expect_fetch(32'h1000_0018 + 32'(4 * i), 1'b1);
        g0 = grant_cnt;
        imem_gnt = 1'b1;
        step(10);
        chk("credit_grants", 32'(grant_cnt - g0), 32'd4);
        chk("credit_req", {31'h0, imem_req}, 32'h0);
        chk("credit_valid", {31'h0, instr_valid}, 32'h1);
        chk("credit_head", instr_pc, 32'h1000_0018);
        for (int i = 0; i < 4; i++) expect_fetch(32'h1000_0028 + 32'(4 * i), 1'b1);
        instr_ready = 1'b1;
        grant_n(4);
        step(8);
        chk("credit_drained", 32'(exp_q.size()), 32'h0);

        // Redirect with 3 outstanding on a 5-cycle memory
        lat = 5;
        expect_fetch(32'h1000_0038, 1'b0);
        expect_fetch(32'h1000_003C, 1'b0);
        expect_fetch(32'h1000_0040, 1'b0);
        grant_n(3);
        redirect = 1'b1;
        redirect_pc = 32'h2000_0042;
        step(1);
        redirect = 1'b0;
        expect_fetch(32'h2000_0040, 1'b1);
        expect_fetch(32'h2000_0044, 1'b1);
        grant_n(2);
        step(15);
        chk("redir_drained", 32'(exp_q.size()), 32'h0);

        // Redirect coinciding with a response and a pop
        lat = 1;
        instr_ready = 1'b0;
        expect_fetch(32'h2000_0048, 1'b0);
        expect_fetch(32'h2000_004C, 1'b0);
        grant_n(2);
        step(3);
        chk("flush_pre_valid", {31'h0, instr_valid}, 32'h1);
        expect_fetch(32'h2000_0050, 1'b0);
        grant_n(1);
        redirect = 1'b1;
        redirect_pc = 32'h3000_0000;
        instr_ready = 1'b1;
        step(1);
        redirect = 1'b0;
        @(negedge clk);
        chk("flush_valid", {31'h0, instr_valid}, 32'h0);
        step(1);
        expect_fetch(32'h3000_0000, 1'b1);
        grant_n(1);
        step(5);

        // Address wrap at the top of the address space
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        step(1);
        redirect = 1'b0;
        expect_fetch(32'hFFFF_FFFC, 1'b1);
        expect_fetch(32'h0000_0000, 1'b1);
        grant_n(2);
        step(5);
        chk("wrap_next_addr", imem_addr, 32'h0000_0004);

        // Asynchronous reset mid-stream with a buffered entry and 2 outstanding
        instr_ready = 1'b0;
        expect_fetch(32'h0000_0004, 1'b0);
        grant_n(1);
        step(3);
        lat = 5;
        expect_fetch(32'h0000_0008, 1'b0);
        expect_fetch(32'h0000_000C, 1'b0);
        grant_n(2);
        chk("pre_rst_valid", {31'h0, instr_valid}, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_req", {31'h0, imem_req}, 32'h0);
        chk("async_valid", {31'h0, instr_valid}, 32'h0);
        chk("async_instr", instr, 32'h0);
        chk("async_pc", instr_pc, 32'h0);
        step(8);
        rst = 1'b0;
        lat = 1;
        instr_ready = 1'b1;
        chk("restart_addr", imem_addr, 32'h1000_0000);
        expect_fetch(32'h1000_0000, 1'b1);
        expect_fetch(32'h1000_0004, 1'b1);
        grant_n(2);
        step(6);

        chk("addr_q_left", 32'(addr_q.size()), 32'h0);
        chk("exp_q_left", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
